// File: rtl/fall_time_sqrt.sv
// fall_time_sqrt: bit-serial restoring square root of a scaled drop height.
// Computes t_act = floor(sqrt(h_scaled) * 2^FRAC_BITS), one root bit per clock.
// Ports: clk, rst_n (async, active-low), start, h_scaled[15:0] in;
//        busy, done (1-cycle pulse), t_act[15:0] (Q(16-F).F) out.
// Optional macro SQRT_ROUND_EN: adds a ROUND state (round-to-nearest, saturating).
module fall_time_sqrt #(
    parameter int FRAC_BITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] h_scaled,
    output logic        busy,
    output logic        done,
    output logic [15:0] t_act
);

    localparam int ITER = 8 + FRAC_BITS;
    localparam int RW   = 2 * ITER;
    localparam int REMW = ITER + 2;
    localparam int CW   = 5;

`ifdef SQRT_ROUND_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_DONE  = 2'd2,
        S_ROUND = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;
`endif

    state_t          state;
    logic [RW-1:0]   rad_q;
    logic [REMW-1:0] rem_q;
    logic [ITER-1:0] root_q;
    logic [CW-1:0]   cnt_q;

    logic [REMW-1:0] rem_sh;
    logic [REMW-1:0] trial;
    logic [REMW-1:0] rem_nx;
    logic [ITER-1:0] root_nx;
    logic            ge;
    logic            last;

    // Bring down the next radicand bit pair; trial divisor is 4*root+1.
    // The remainder never exceeds 2*root, so the shift loses nothing.
    always_comb begin
        rem_sh  = (rem_q << 2) | REMW'(rad_q[RW-1 -: 2]);
        trial   = {root_q, 2'b01};
        ge      = (rem_sh >= trial);
        rem_nx  = ge ? (rem_sh - trial) : rem_sh;
        root_nx = {root_q[ITER-2:0], ge};
        last    = (cnt_q == CW'(ITER - 1));
    end

`ifdef SQRT_ROUND_EN
    logic [16:0] root_inc;
    logic [15:0] rounded;

    // x - r^2 > r  <=>  sqrt(x) >= r + 0.5 for integer x, r.
    always_comb begin
        root_inc = 17'(root_q) + 17'd1;
        rounded  = 16'(root_q);
        if (rem_q > REMW'(root_q)) begin
            rounded = root_inc[16] ? 16'hFFFF : root_inc[15:0];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            t_act  <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        rad_q  <= RW'(h_scaled) << (2 * FRAC_BITS);
                        rem_q  <= '0;
                        root_q <= '0;
                        cnt_q  <= '0;
                        busy   <= 1'b1;
                        state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    rem_q  <= rem_nx;
                    root_q <= root_nx;
                    rad_q  <= rad_q << 2;
                    cnt_q  <= cnt_q + 1'b1;
                    if (last) begin
`ifdef SQRT_ROUND_EN
                        state <= S_ROUND;
`else
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        t_act <= 16'(root_nx);
`endif
                    end
                end
`ifdef SQRT_ROUND_EN
                S_ROUND: begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    t_act <= rounded;
                end
`endif
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fall_time_sqrt.sv
// tb_fall_time_sqrt: scoreboard bench for fall_time_sqrt (FRAC_BITS=8).
// Directed vectors; a negedge monitor pops expected results on each done.
module tb_fall_time_sqrt;

    localparam int ITER = 16;
`ifdef SQRT_ROUND_EN
    localparam int LAT  = ITER + 2;
    localparam int BUSYC = ITER + 1;
    localparam logic [15:0] E10 = 16'h032A;
`else
    localparam int LAT  = ITER + 1;
    localparam int BUSYC = ITER;
    localparam logic [15:0] E10 = 16'h0329;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] h_scaled;
    logic        busy;
    logic        done;
    logic [15:0] t_act;

    int checks;
    int fails;
    int ndone;
    logic [15:0] exp_q[$];
    logic [15:0] e;

    fall_time_sqrt #(.FRAC_BITS(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .h_scaled (h_scaled),
        .busy     (busy),
        .done     (done),
        .t_act    (t_act)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare every completion against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (busy && done) begin
                fails++;
                $display("FAIL busy_done_overlap busy=%b done=%b", busy, done);
            end
            if (done) begin
                ndone++;
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_done t_act=%h", t_act);
                end else begin
                    e = exp_q.pop_front();
                    if (t_act !== e) begin
                        fails++;
                        $display("FAIL result got=%h exp=%h", t_act, e);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic run(input logic [15:0] h, input logic [15:0] x,
                       input bit disturb);
        int edges;
        int bcnt;
        int nd0;
        logic [15:0] prev;
        prev = t_act;
        nd0  = ndone;
        @(negedge clk);
        h_scaled = h;
        start    = 1'b1;
        exp_q.push_back(x);
        @(posedge clk);
        edges = 1;
        #1;
        start = 1'b0;
        bcnt  = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            if (busy) bcnt++;
            checks++;
            if (t_act !== prev) begin
                fails++;
                $display("FAIL hold got=%h exp=%h", t_act, prev);
            end
            if (disturb && edges == 5) begin
                start    = 1'b1;
                h_scaled = 16'd7;
            end
            if (disturb && edges == 8) start = 1'b0;
            if (edges > 100) begin
                fails++;
                $display("FAIL timeout got=%0d exp=%0d", edges, LAT);
                break;
            end
            @(posedge clk);
            edges++;
        end
        chk("latency", edges, LAT);
        chk("busy_cycles", bcnt, BUSYC);
        repeat (3) @(negedge clk);
        chk("done_count", ndone, nd0 + 1);
    endtask

    initial begin
        int nd0;
        checks   = 0;
        fails    = 0;
        ndone    = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        h_scaled = 16'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_t_act", int'(t_act), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run(16'd1,     16'h0100, 1'b0);
        run(16'd10,    E10,      1'b0);
        run(16'd3,     16'h01BB, 1'b0);
        run(16'd100,   16'h0A00, 1'b0);
        run(16'hFFFF,  16'hFFFF, 1'b0);
        run(16'd2,     16'h016A, 1'b1);

        // Abort a computation mid-flight.
        nd0 = ndone;
        @(negedge clk);
        h_scaled = 16'd4;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_t_act", int'(t_act), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_no_done", ndone, nd0);

        run(16'd4,     16'h0200, 1'b0);
        run(16'd0,     16'h0000, 1'b0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
